// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of a five-stage MIPS pipeline.
// Owns the PC and runs a req/ack handshake to instruction memory.
// Drives the IF/ID pipeline register. A one-entry hold buffer keeps an
// already-fetched instruction across a stall, so memory is never re-read.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        Flush,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] IF_PC
);

  // REQ  : request outstanding at the PC
  // HOLD : instruction parked in the buffer while the pipeline is stalled
  // DRAIN: a redirect arrived before the ack; wait out the old request
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] r_target;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;

  logic        w_accept;
  logic        w_have_instr;
  logic [31:0] w_instr;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  // Either stall control low, or a redirect, prevents consuming an instruction.
  assign w_accept   = PCWrite & IF_ID_Write & ~Flush;
  // Redirect targets are always word aligned; the low two bits are dropped.
  assign w_target   = BranchTarget & 32'hFFFF_FFFC;
  // Wraps modulo 2^32 by construction.
  assign w_pc_plus4 = r_pc + 32'd4;

  // An instruction is available from the buffer in HOLD, or straight from
  // memory when the ack lands in REQ. Data acked in DRAIN is stale and dropped.
  assign w_have_instr = (r_state == S_HOLD) | ((r_state == S_REQ) & imem_ack);
  assign w_instr      = (r_state == S_HOLD) ? r_buf : imem_rdata;

  assign imem_req      = r_req;
  assign imem_addr     = r_pc;
  assign IF_PC         = r_pc;
  assign IF_ID_Instr   = r_ifid_instr;
  assign IF_ID_PCPlus4 = r_ifid_pc4;
  assign IF_ID_Valid   = r_ifid_valid;

  // Fetch FSM, PC, hold buffer and IF/ID register, all updated together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_req        <= 1'b1;
      r_pc         <= RESET_PC;
      r_buf        <= NOP_INSTR;
      r_target     <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else begin
      // IF/ID: a redirect always bubbles, even over a stall.
      if (Flush) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_pc4   <= 32'd0;
        r_ifid_valid <= 1'b0;
      end else if (IF_ID_Write) begin
        if (w_accept && w_have_instr) begin
          r_ifid_instr <= w_instr;
          r_ifid_pc4   <= w_pc_plus4;
          r_ifid_valid <= 1'b1;
        end else begin
          r_ifid_instr <= NOP_INSTR;
          r_ifid_pc4   <= 32'd0;
          r_ifid_valid <= 1'b0;
        end
      end

      case (r_state)
        S_REQ: begin
          if (imem_ack) begin
            if (w_accept) begin
              r_pc <= w_pc_plus4;
            end else if (Flush) begin
              r_pc <= w_target;
            end else begin
              // Stalled: park the data and stop requesting.
              r_buf   <= imem_rdata;
              r_state <= S_HOLD;
              r_req   <= 1'b0;
            end
          end else if (Flush) begin
            // The address must stay stable until ack, so remember the target.
            r_target <= w_target;
            r_state  <= S_DRAIN;
          end
        end

        S_HOLD: begin
          if (w_accept) begin
            r_pc    <= w_pc_plus4;
            r_buf   <= NOP_INSTR;
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end else if (Flush) begin
            r_pc    <= w_target;
            r_buf   <= NOP_INSTR;
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (imem_ack) begin
            // A flush coinciding with the ack is the most recent one.
            r_pc    <= Flush ? w_target : r_target;
            r_state <= S_REQ;
          end else if (Flush) begin
            r_target <= w_target;
          end
        end

        default: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed vector table, randomized run against
// a behavioural model, PC wrap-around and asynchronous reset during DRAIN.
`timescale 1ns/1ps
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset2 = 1'b1;
  logic        pw = 1'b1, iw = 1'b1, fl = 1'b0, ack = 1'b0;
  logic [31:0] bt = 32'd0, rdata = 32'd0;

  logic        req, valid;
  logic [31:0] addr, instr, pc4, ifpc;
  logic        d2_req, d2_valid;
  logic [31:0] d2_addr, d2_instr, d2_pc4, d2_ifpc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_stage u_dut (
    .clk(clk), .reset(reset), .PCWrite(pw), .IF_ID_Write(iw), .Flush(fl),
    .BranchTarget(bt), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
    .imem_rdata(rdata), .IF_ID_Instr(instr), .IF_ID_PCPlus4(pc4),
    .IF_ID_Valid(valid), .IF_PC(ifpc)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .reset(reset2), .PCWrite(pw), .IF_ID_Write(iw), .Flush(fl),
    .BranchTarget(bt), .imem_req(d2_req), .imem_addr(d2_addr), .imem_ack(ack),
    .imem_rdata(rdata), .IF_ID_Instr(d2_instr), .IF_ID_PCPlus4(d2_pc4),
    .IF_ID_Valid(d2_valid), .IF_PC(d2_ifpc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid);
    chk({tag, " req"},   {31'd0, req},   {31'd0, e_req});
    chk({tag, " addr"},  addr,           e_addr);
    chk({tag, " if_pc"}, ifpc,           e_addr);
    chk({tag, " instr"}, instr,          e_instr);
    chk({tag, " pc4"},   pc4,            e_pc4);
    chk({tag, " valid"}, {31'd0, valid}, {31'd0, e_valid});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic pw, iw, fl; logic [31:0] bt; logic ack; logic [31:0] rd;
    logic e_req; logic [31:0] e_addr, e_instr, e_pc4; logic e_valid;
  } vec_t;

  localparam int NV = 25;
  vec_t vt[NV];

  function automatic logic [31:0] dd(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  function automatic vec_t mk(input logic p, input logic i, input logic f, input logic [31:0] b,
                              input logic a, input logic [31:0] r, input logic er,
                              input logic [31:0] ea, input logic [31:0] ei,
                              input logic [31:0] ep, input logic ev);
    vec_t v;
    v.pw = p; v.iw = i; v.fl = f; v.bt = b; v.ack = a; v.rd = r;
    v.e_req = er; v.e_addr = ea; v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc, m_held_instr, m_redirect_to, m_instr, m_pc4;
  logic        m_held, m_redirect, m_valid;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_held = 1'b0; m_held_instr = 32'd0;
    m_redirect = 1'b0; m_redirect_to = 32'd0;
    m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic        have;
    logic [31:0] got;
    logic [31:0] tgt;
    logic        acc;
    have = 1'b0; got = 32'd0;
    tgt  = {bt[31:2], 2'b00};
    acc  = pw && iw && !fl;
    if (m_held) begin
      have = 1'b1; got = m_held_instr;
    end else if (ack && !m_redirect) begin
      have = 1'b1; got = rdata;
    end
    if (fl) begin
      m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    end else if (iw) begin
      if (acc && have) begin
        m_instr = got; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end else begin
        m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      end
    end
    if (m_redirect) begin
      if (fl) m_redirect_to = tgt;
      if (ack) begin
        m_pc = m_redirect_to; m_redirect = 1'b0;
      end
    end else if (have) begin
      if (acc) begin
        m_pc = m_pc + 32'd4; m_held = 1'b0;
      end else if (fl) begin
        m_pc = tgt; m_held = 1'b0;
      end else begin
        m_held = 1'b1; m_held_instr = got;
      end
    end else if (fl) begin
      m_redirect = 1'b1; m_redirect_to = tgt;
    end
  endtask

  initial begin
    // Test plan 1..5 as one continuous sequence; D(a) = memory data at a.
    vt[0]  = mk(1,1,0,32'h0,  1,dd(32'h0),    1,32'h04, dd(32'h00),32'h04,1);
    vt[1]  = mk(1,1,0,32'h0,  1,dd(32'h4),    1,32'h08, dd(32'h04),32'h08,1);
    vt[2]  = mk(1,1,0,32'h0,  1,dd(32'h8),    1,32'h0C, dd(32'h08),32'h0C,1);
    vt[3]  = mk(1,1,0,32'h0,  1,dd(32'hC),    1,32'h10, dd(32'h0C),32'h10,1);
    vt[4]  = mk(0,0,0,32'h0,  1,dd(32'h10),   0,32'h10, dd(32'h0C),32'h10,1);
    vt[5]  = mk(1,1,0,32'h0,  1,32'hDEAD_BEEF,1,32'h14, dd(32'h10),32'h14,1);
    vt[6]  = mk(1,1,0,32'h0,  1,dd(32'h14),   1,32'h18, dd(32'h14),32'h18,1);
    vt[7]  = mk(1,1,0,32'h0,  1,dd(32'h18),   1,32'h1C, dd(32'h18),32'h1C,1);
    vt[8]  = mk(1,1,0,32'h0,  1,dd(32'h1C),   1,32'h20, dd(32'h1C),32'h20,1);
    vt[9]  = mk(1,1,1,32'h40, 1,dd(32'h20),   1,32'h40, 32'h0,     32'h0, 0);
    vt[10] = mk(1,1,0,32'h0,  1,dd(32'h40),   1,32'h44, dd(32'h40),32'h44,1);
    vt[11] = mk(1,1,1,32'h30, 1,dd(32'h44),   1,32'h30, 32'h0,     32'h0, 0);
    vt[12] = mk(1,1,1,32'h70, 0,32'h0,        1,32'h30, 32'h0,     32'h0, 0);
    vt[13] = mk(1,1,0,32'h0,  0,32'h0,        1,32'h30, 32'h0,     32'h0, 0);
    vt[14] = mk(1,1,1,32'h80, 0,32'h0,        1,32'h30, 32'h0,     32'h0, 0);
    vt[15] = mk(1,1,0,32'h0,  1,dd(32'h30),   1,32'h80, 32'h0,     32'h0, 0);
    vt[16] = mk(1,1,0,32'h0,  1,dd(32'h80),   1,32'h84, dd(32'h80),32'h84,1);
    vt[17] = mk(1,0,1,32'hC0, 1,dd(32'h84),   1,32'hC0, 32'h0,     32'h0, 0);
    vt[18] = mk(1,1,0,32'h0,  1,dd(32'hC0),   1,32'hC4, dd(32'hC0),32'hC4,1);
    vt[19] = mk(1,0,0,32'h0,  0,32'h0,        1,32'hC4, dd(32'hC0),32'hC4,1);
    vt[20] = mk(1,1,0,32'h0,  0,32'h0,        1,32'hC4, 32'h0,     32'h0, 0);
    vt[21] = mk(1,1,0,32'h0,  1,dd(32'hC4),   1,32'hC8, dd(32'hC4),32'hC8,1);
    vt[22] = mk(0,1,0,32'h0,  1,dd(32'hC8),   0,32'hC8, 32'h0,     32'h0, 0);
    vt[23] = mk(1,1,1,32'h103,0,32'h0,        1,32'h100,32'h0,     32'h0, 0);
    vt[24] = mk(1,1,0,32'h0,  1,dd(32'h100),  1,32'h104,dd(32'h100),32'h104,1);

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk_all("reset", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);

    // Directed table
    for (int i = 0; i < NV; i++) begin
      pw = vt[i].pw; iw = vt[i].iw; fl = vt[i].fl; bt = vt[i].bt;
      ack = vt[i].ack; rdata = vt[i].rd;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr,
              vt[i].e_instr, vt[i].e_pc4, vt[i].e_valid);
    end

    // Randomized run against the model
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      chk_all($sformatf("rnd%0d", c), !m_held, m_pc, m_instr, m_pc4, m_valid);
      pw  = ($urandom % 4) != 0;
      iw  = ($urandom % 4) != 0;
      fl  = ($urandom % 7) == 0;
      bt  = $urandom;
      ack = ($urandom % 3) != 0;
      rdata = m_held ? $urandom : memfn(m_pc);
      model_step();
      @(negedge clk);
    end
    chk_all("rnd_end", !m_held, m_pc, m_instr, m_pc4, m_valid);

    // PC wrap: RESET_PC = FFFF_FFFC
    pw = 1'b1; iw = 1'b1; fl = 1'b0; ack = 1'b0; bt = 32'd0;
    #1;
    chk("wrap reset addr",  d2_addr,  32'hFFFF_FFFC);
    chk("wrap reset valid", {31'd0, d2_valid}, 32'd0);
    reset2 = 1'b0; ack = 1'b1; rdata = 32'hABCD_0001;
    @(negedge clk);
    chk("wrap instr", d2_instr, 32'hABCD_0001);
    chk("wrap pc4",   d2_pc4,   32'h0);
    chk("wrap valid", {31'd0, d2_valid}, 32'd1);
    chk("wrap addr",  d2_addr,  32'h0);
    chk("wrap req",   {31'd0, d2_req}, 32'd1);
    rdata = 32'hABCD_0002;
    @(negedge clk);
    chk("wrap2 instr", d2_instr, 32'hABCD_0002);
    chk("wrap2 pc4",   d2_pc4,   32'h4);
    chk("wrap2 addr",  d2_addr,  32'h4);

    // Asynchronous reset while in DRAIN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; ack = 1'b1; rdata = 32'h5555_0000;
    @(negedge clk);
    chk_all("dr pre", 1'b1, 32'h4, 32'h5555_0000, 32'h4, 1'b1);
    fl = 1'b1; bt = 32'h200; ack = 1'b0;
    @(negedge clk);
    fl = 1'b0;
    chk_all("dr drain", 1'b1, 32'h4, 32'h0, 32'h0, 1'b0);
    #2 reset = 1'b1;
    #1 chk_all("dr async", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0; ack = 1'b1; rdata = 32'h6666_0000;
    @(negedge clk);
    chk_all("dr restart", 1'b1, 32'h4, 32'h6666_0000, 32'h4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
